// File: rtl/cpu_pkg.sv
// Shared CPU types: LSU state encoding and load/store width codes.
// These width codes match the decoder's LB/SB funct3 encodings.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_width_t;

    // Unsigned widths are meaningless on stores, so they collapse to a word access.
    function automatic ls_width_t ls_normalize(input logic [2:0] f3, input logic is_store);
        ls_width_t w;
        case (f3)
            3'b000:  w = LS_B;
            3'b001:  w = LS_H;
            3'b100:  w = is_store ? LS_W : LS_BU;
            3'b101:  w = is_store ? LS_W : LS_HU;
            default: w = LS_W;
        endcase
        return w;
    endfunction

    function automatic logic ls_misaligned(input ls_width_t w, input logic [1:0] lo);
        logic m;
        case (w)
            LS_H, LS_HU: m = lo[0];
            LS_W:        m = (lo != 2'b00);
            default:     m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store lane enables/replication and load
// extraction with sign or zero extension.
module lsu_lane_align
    import cpu_pkg::*;
(
    input  logic [2:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_ext
);

    logic [31:0] shifted;

    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        sel      = '0;
        wdata    = '0;
        load_ext = '0;
        case (ls_width_t'(width))
            LS_B, LS_BU: begin
                sel   = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            LS_H, LS_HU: begin
                sel   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                sel   = 4'b1111;
                wdata = store_data;
            end
        endcase
        case (ls_width_t'(width))
            LS_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            LS_BU:   load_ext = {24'b0, shifted[7:0]};
            LS_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            LS_HU:   load_ext = {16'b0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one bus transaction per request, stalls until done.
// Optional LSU_TIMEOUT_EN aborts a transaction after TIMEOUT_CYCLES without bus_ack.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              mem_req,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              store_done,
    output logic              misaligned,
    output logic              bus_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_sel,
    output logic              bus_read,
    output logic              bus_write,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    ls_width_t         width_q, width_d;
    logic [31:0]       sdata_q, sdata_d;
    logic              is_load_q, is_load_d;
    logic              mis_q, mis_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              err_now;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    assign err_now = err_q;
`else
    assign err_now = 1'b0;
`endif

    logic        accept;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    lsu_lane_align u_lane_align (
        .width      (width_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (bus_rdata),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_ext   (lane_load)
    );

    assign accept = mem_req & (mem_read ^ mem_write);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        width_d     = width_q;
        sdata_d     = sdata_q;
        is_load_d   = is_load_q;
        mis_d       = mis_q;
        load_data_d = load_data_q;
        busy        = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    busy      = 1'b1;
                    addr_d    = addr;
                    width_d   = ls_normalize(funct3, mem_write);
                    sdata_d   = store_data;
                    is_load_d = mem_read;
                    mis_d     = ls_misaligned(width_d, addr[1:0]);
`ifdef LSU_TIMEOUT_EN
                    cnt_d     = '0;
                    err_d     = 1'b0;
`endif
                    if (mis_d) begin
                        state_d = DONE;
                        if (mem_read) load_data_d = '0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (bus_ack) begin
                    state_d = DONE;
                    if (is_load_q) load_data_d = lane_load;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            width_q     <= LS_B;
            sdata_q     <= '0;
            is_load_q   <= 1'b0;
            mis_q       <= 1'b0;
            load_data_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            width_q     <= width_d;
            sdata_q     <= sdata_d;
            is_load_q   <= is_load_d;
            mis_q       <= mis_d;
            load_data_q <= load_data_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Bus outputs come only from the latched request, so they hold steady while waiting.
    logic in_wait;
    assign in_wait    = (state_q == WAIT);
    assign bus_read   = in_wait & is_load_q;
    assign bus_write  = in_wait & ~is_load_q;
    assign bus_addr   = in_wait ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus_sel    = in_wait ? lane_sel : '0;
    assign bus_wdata  = (in_wait & ~is_load_q) ? lane_wdata : '0;

    assign load_data  = load_data_q;
    assign load_valid = (state_q == DONE) & is_load_q & ~mis_q & ~err_now;
    assign store_done = (state_q == DONE) & ~is_load_q & ~mis_q & ~err_now;
    assign misaligned = (state_q == DONE) & mis_q;
    assign bus_err    = (state_q == DONE) & err_now;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed transactions with a
// rule-level model of lanes, extension and per-cycle handshake expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        nRst;
    logic        mem_req, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, load_valid, store_done, misaligned, bus_err;
    logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;
    logic        bus_read, bus_write, bus_ack;

    int n_checks = 0;
    int n_errors = 0;

    logic        chk_en = 1'b0;
    logic        exp_busy, exp_rd, exp_wr, exp_lv, exp_sd, exp_mis, exp_err;
    logic [31:0] exp_ld, exp_addr, exp_wdata;
    logic [3:0]  exp_sel;
    logic        chk_bus, chk_wd;
    logic [3:0]  seen_sel;
    logic [31:0] seen_addr, seen_wdata;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(255)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .mem_req    (mem_req),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .load_data  (load_data),
        .load_valid (load_valid),
        .store_done (store_done),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_sel    (bus_sel),
        .bus_read   (bus_read),
        .bus_write  (bus_write),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: access size in bytes from the width code and direction.
    function automatic int nbytes(input logic [2:0] f3, input logic st);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_sel(input int nb, input logic [31:0] a);
        int s;
        s = ((1 << nb) - 1) << (a % 4);
        return (nb == 4) ? 4'hF : s[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int nb, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[7:0];
        h = d[15:0];
        if (nb == 1) return 32'(b) * 32'h0101_0101;
        if (nb == 2) return 32'(h) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int     nb;
        longint v, span;
        nb   = nbytes(f3, 1'b0);
        span = 64'd1 << (8 * nb);
        v    = longint'(rd) >> (8 * (a % 4));
        v    = v % span;
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic exp_quiet();
        exp_busy = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_lv = 1'b0;
        exp_sd = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
        chk_bus = 1'b0; chk_wd = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("bus_read", 32'(bus_read), 32'(exp_rd));
            check("bus_write", 32'(bus_write), 32'(exp_wr));
            check("load_valid", 32'(load_valid), 32'(exp_lv));
            check("store_done", 32'(store_done), 32'(exp_sd));
            check("misaligned", 32'(misaligned), 32'(exp_mis));
            check("bus_err", 32'(bus_err), 32'(exp_err));
            check("load_data", load_data, exp_ld);
            if (chk_bus) begin
                check("bus_sel", 32'(bus_sel), 32'(exp_sel));
                check("bus_addr", bus_addr, exp_addr);
            end
            if (chk_wd) check("bus_wdata", bus_wdata, exp_wdata);
        end
        if (bus_read || bus_write) begin
            seen_sel   = bus_sel;
            seen_addr  = bus_addr;
            seen_wdata = bus_wdata;
        end
    end

    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                       input int delay, input bit hold);
        int nb;
        nb = nbytes(f3, wr);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = d;
        exp_quiet();
        exp_busy = 1'b1;
        if ((a % nb) != 0) begin
            @(posedge clk); #1;
            if (!hold) mem_req = 1'b0;
            exp_quiet();
            exp_mis = 1'b1;
            if (rd) exp_ld = '0;
        end else begin
            for (int k = 0; k <= delay; k++) begin
                @(posedge clk); #1;
                if (!hold) mem_req = 1'b0;
                exp_quiet();
                exp_busy  = 1'b1;
                exp_rd    = rd;
                exp_wr    = wr;
                chk_bus   = 1'b1;
                chk_wd    = wr;
                exp_sel   = model_sel(nb, a);
                exp_addr  = a & ~32'd3;
                exp_wdata = model_wdata(nb, d);
                bus_ack   = (k == delay);
                bus_rdata = (k == delay) ? rdat : 32'h5A5A_A5A5;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            bus_rdata = 32'hA5A5_5A5A;
            exp_quiet();
            exp_lv = rd;
            exp_sd = wr;
            if (rd) exp_ld = model_load(f3, a, rdat);
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
        exp_quiet();
    endtask

    task automatic ignored_req(input logic rd, input logic wr);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_read = rd; mem_write = wr; funct3 = 3'd2; addr = 32'h500;
        exp_quiet();
        @(posedge clk); #1;
        mem_req = 1'b0;
        exp_quiet();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within bound");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRst = 1'b0; mem_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        addr = '0; store_data = '0; bus_rdata = '0; bus_ack = 1'b0;
        exp_quiet();
        exp_ld = '0; exp_sel = '0; exp_addr = '0; exp_wdata = '0;
        chk_bus = 1'b1; chk_wd = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        nRst = 1'b1;
        exp_quiet();

        txn(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        check("lw_data_lit", load_data, 32'hDEAD_BEEF);
        check("lw_sel_lit", 32'(seen_sel), 32'hF);
        check("lw_addr_lit", seen_addr, 32'h100);

        txn(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 1, 0);
        check("lb_data_lit", load_data, 32'hFFFF_FF80);
        check("lb_sel_lit", 32'(seen_sel), 32'h8);
        txn(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
        check("lbu_data_lit", load_data, 32'h0000_0080);
        txn(1, 0, 3'd5, 32'h102, 32'h0, 32'h80FF_0000, 0, 0);
        check("lhu_data_lit", load_data, 32'h0000_80FF);
        txn(1, 0, 3'd1, 32'h102, 32'h0, 32'h80FF_0000, 2, 0);
        check("lh_data_lit", load_data, 32'hFFFF_80FF);
        txn(1, 0, 3'd0, 32'h100, 32'h0, 32'h0000_007F, 0, 0);

        txn(0, 1, 3'd0, 32'h201, 32'h1234_56AB, 32'h0, 3, 0);
        check("sb_sel_lit", 32'(seen_sel), 32'h2);
        check("sb_wdata_lit", seen_wdata, 32'hABAB_ABAB);
        txn(0, 1, 3'd1, 32'h202, 32'h0000_BEEF, 32'h0, 1, 0);
        check("sh_wdata_lit", seen_wdata, 32'hBEEF_BEEF);
        txn(0, 1, 3'd2, 32'h204, 32'hCAFE_F00D, 32'h0, 0, 0);
        check("sw_addr_lit", seen_addr, 32'h204);

        txn(1, 0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 0);
        check("lh_mis_data_lit", load_data, 32'h0);
        txn(0, 1, 3'd2, 32'h202, 32'h1111_2222, 32'h0, 0, 0);
        txn(0, 1, 3'd4, 32'h301, 32'h3333_4444, 32'h0, 0, 0);
        txn(1, 0, 3'd7, 32'h208, 32'h0, 32'h1122_3344, 0, 0);
        check("inv_f3_lit", load_data, 32'h1122_3344);

        ignored_req(1, 1);
        ignored_req(0, 0);

        txn(1, 0, 3'd2, 32'h400, 32'h0, 32'h0BAD_F00D, 1, 1);
        repeat (2) @(posedge clk);

        // Reset in the middle of a pending load.
        @(posedge clk); #1;
        mem_req = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h300;
        exp_quiet(); exp_busy = 1'b1;
        @(posedge clk); #1;
        mem_req = 1'b0;
        exp_quiet(); exp_busy = 1'b1; exp_rd = 1'b1;
        chk_bus = 1'b1; exp_sel = 4'hF; exp_addr = 32'h300;
        #2;
        nRst = 1'b0;
        exp_quiet(); exp_ld = '0;
        chk_bus = 1'b1; exp_sel = '0; exp_addr = '0;
        #1;
        check("rst_bus_read_now", 32'(bus_read), 32'h0);
        check("rst_busy_now", 32'(busy), 32'h0);
        @(posedge clk); #1;
        nRst = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        exp_quiet();
        @(posedge clk); #1;
        bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
